// File: rtl/bcd_click_counter.sv
// rtl/bcd_click_counter.sv - debounced three-key multi-digit counter with multiplexed seven-segment drive
//
// Ports:
//   clk        sole clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   clr_key    raw clear button, high = pressed, asynchronous to clk
//   inc_key    raw increment button, high = pressed, asynchronous to clk
//   dec_key    raw decrement button, high = pressed, asynchronous to clk
//   count      counter value, digit i at [4i+3:4i], digit 0 least significant
//   segm       active-low segments {g,f,e,d,c,b,a} of the scanned digit
//   digit_sel  active-low one-hot enable of the scanned digit
//   ovf        one-cycle pulse on inc at maximum or dec at zero
module bcd_click_counter #(
    parameter int DIGITS          = 4,
    parameter int DECIMAL         = 1,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_key,
    input  logic                  inc_key,
    input  logic                  dec_key,
    output logic [4*DIGITS-1:0]   count,
    output logic [6:0]            segm,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  ovf
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DIGIT_MAX = (DECIMAL != 0) ? 4'd9 : 4'hF;
    localparam logic [DIGITS-1:0] SEL_RESET = ~DIGITS'(1);

    // Key index: 0 = clear, 1 = increment, 2 = decrement
    logic [2:0]      raw_keys;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      accepted;
    logic [2:0]      press;
    logic [DB_W-1:0] stable_cnt [3];

    assign raw_keys = {dec_key, inc_key, clr_key};

    // The filter counts consecutive cycles the synchronised level disagrees
    // with the accepted level; any agreement restarts the count, so short
    // glitches never reach the threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            accepted <= '0;
            press    <= '0;
            for (int k = 0; k < 3; k++) begin
                stable_cnt[k] <= '0;
            end
        end else begin
            sync1 <= raw_keys;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == accepted[k]) begin
                    stable_cnt[k] <= '0;
                end else if (stable_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    accepted[k]   <= sync2[k];
                    stable_cnt[k] <= '0;
                    // only an accepted rising level is an event
                    press[k]      <= sync2[k];
                end else begin
                    stable_cnt[k] <= stable_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Ripple increment / decrement. A carry or borrow out of the top digit
    // means the counter was at MAX or zero; the rippled value is then
    // already the wrapped result.
    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic                carry;
    logic                borrow;

    always_comb begin
        inc_val = count;
        dec_val = count;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == DIGIT_MAX) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = DIGIT_MAX;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (press[0]) begin
                count <= '0;
            end else if (press[1] && press[2]) begin
                count <= count;
            end else if (press[1]) begin
                ovf <= carry;
                if (!carry || WRAP != 0) begin
                    count <= inc_val;
                end
            end else if (press[2]) begin
                ovf <= borrow;
                if (!borrow || WRAP != 0) begin
                    count <= dec_val;
                end
            end
        end
    end

    // Display scan
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_idx_next;
    logic [DIV_W-1:0]  scan_div;
    logic [DIGITS-1:0] sel_next;

    always_comb begin
        scan_idx_next = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        sel_next      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_next == IDX_W'(i)) begin
                sel_next[i] = 1'b0;
            end
        end
    end

    // digit_sel is registered alongside the index so it always matches it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx  <= '0;
            scan_div  <= '0;
            digit_sel <= SEL_RESET;
        end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
            scan_div  <= '0;
            scan_idx  <= scan_idx_next;
            digit_sel <= sel_next;
        end else begin
            scan_div <= scan_div + 1'b1;
        end
    end

    logic [3:0] shown_digit;

    always_comb begin
        shown_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                shown_digit = count[4*i +: 4];
            end
        end
    end

    always_comb begin
        segm = 7'b1111111;
        case (shown_digit)
            4'h0: segm = 7'b1000000;
            4'h1: segm = 7'b1111001;
            4'h2: segm = 7'b0100100;
            4'h3: segm = 7'b0110000;
            4'h4: segm = 7'b0011001;
            4'h5: segm = 7'b0010010;
            4'h6: segm = 7'b0000010;
            4'h7: segm = 7'b1111000;
            4'h8: segm = 7'b0000000;
            4'h9: segm = 7'b0010000;
            4'hA: segm = 7'b0001000;
            4'hB: segm = 7'b0000011;
            4'hC: segm = 7'b1000110;
            4'hD: segm = 7'b0100001;
            4'hE: segm = 7'b0000110;
            4'hF: segm = 7'b0001110;
            default: segm = 7'b1111111;
        endcase
    end

endmodule

// File: doc/bcd_click_counter.md
# bcd_click_counter

Parametrised multi-digit click counter with debounced push-button inputs and a time-multiplexed seven-segment display driver. Three buttons (clear, increment, decrement) update a DIGITS-wide counter in hexadecimal or BCD radix, with wrap-around or saturation at the limits. The block sits between the board's raw key pins and the shared-segment display (common segment bus plus per-digit enables).

## Interface
- DIGITS, 4: number of 4-bit digits, 1..8.
- DECIMAL, 1: 1 = BCD digits 0-9; 0 = hex digits 0-F.
- WRAP, 1: 1 = wrap at limits; 0 = saturate.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a level change, ≥1.
- SCAN_DIV, 2: clock cycles each digit is displayed, ≥1.

- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clr_key  in  1  raw clear button, high = pressed, asynchronous.
- inc_key  in  1  raw increment button, high = pressed, asynchronous.
- dec_key  in  1  raw decrement button, high = pressed, asynchronous.
- count  out  4*DIGITS  counter value; digit i is bits [4i+3:4i], digit 0 least significant.
- segm  out  7  active-low segments {g,f,e,d,c,b,a} of the currently scanned digit.
- digit_sel  out  DIGITS  active-low one-hot digit enable.
- ovf  out  1  one-cycle pulse on any inc at maximum or dec at zero.

## Operation
- Per key: 2-flop synchroniser, then a filter holding an accepted level and a stability counter.
  - Synchronised level ≠ accepted level: counter increments; on reaching DEBOUNCE_CYCLES, accepted level takes the new value and the counter clears.
  - Synchronised level = accepted level: counter clears. Any glitch shorter than DEBOUNCE_CYCLES is discarded.
  - A press event is a registered one-cycle pulse on an accepted 0→1 transition. Releases generate no event.
- Count update on a cycle with events, in priority order:
  - clr → count = 0, regardless of inc/dec.
  - inc and dec together → unchanged, ovf = 0.
  - inc only → +1.
  - dec only → −1.
- Arithmetic: per-digit ripple carry/borrow. Digit max is 9 (DECIMAL=1) or F (DECIMAL=0). MAX = all digits at max.
- Limits:
  - inc at MAX → 0 if WRAP, else held at MAX.
  - dec at 0 → MAX if WRAP, else held at 0.
  - ovf pulses in both modes.
- Scan:
  - Digit index 0..DIGITS−1 advances every SCAN_DIV cycles and wraps to 0.
  - digit_sel = ~(1 << index).
  - segm = combinational decode of the selected digit: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.

## Timing
- Reset (rst_n low at an edge) clears: count = 0, ovf = 0, all synchroniser/filter/pulse state = 0, scan index = 0, scan divider = 0. Outputs after reset: digit_sel = all ones except bit 0 low, segm = 1000000.
- Reset mid-debounce or mid-scan abandons the operation; there is no pending event.
- A key held high through reset produces exactly one press event after rst_n rises.
- Key latency: key first sampled high at edge E, held stable. The press pulse is high in the cycle after edge E+1+DEBOUNCE_CYCLES. count/ovf change at edge E+2+DEBOUNCE_CYCLES.
- A key held indefinitely produces exactly one event; there is no auto-repeat.
- count, digit_sel and ovf are registered. segm is a combinational function of registered state.
- digit_sel changes every SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.

## Test plan
- Reset, then wait: with DIGITS=4, DECIMAL=1, WRAP=1, DEBOUNCE_CYCLES=4, SCAN_DIV=2 → count=0x0000, ovf=0. digit_sel cycles 1110, 1101, 1011, 0111 for 2 cycles each; segm=1000000 throughout.
- inc_key high for 20 cycles, sampled first at edge E → count=0x0001 at edge E+6 exactly, ovf never set, no further change while held. Bounce: inc_key high 3 cycles, low 1, high 3, low → count unchanged.
- Radix carry (DECIMAL=1): 10 inc presses → 0x0010, with segm for digit 1 = 1111001 when digit_sel=1101. Same with DECIMAL=0 → 0x000A; digit 0 segm=0001000.
- Wrap (WRAP=1): dec press from 0 → 0x9999 plus one ovf pulse. inc press then → 0x0000 plus ovf. Saturate (WRAP=0): dec at 0 → 0x0000 plus ovf.
- Simultaneous events: at count=0x0005, inc+dec pulses on the same cycle → 0x0005, ovf=0. clr+inc on the same cycle → 0x0000.
- rst_n low for one edge while inc_key is mid-debounce (2 stable cycles) → no increment from that partial press. Key still held → exactly one increment, DEBOUNCE_CYCLES+2 edges after rst_n rises.
